// File: rtl/feg_pkg.sv
// ============================================================================
// Module   : feg_pkg
// Purpose  : Shared types and constants for the FEG control sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package feg_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    WB    = 3'd3,
    DONE  = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    LDR   = 3'd0,
    STR   = 3'd1,
    MOV   = 3'd2,
    XOR   = 3'd3,
    AND   = 3'd4,
    SHIFT = 3'd5,
    CMP   = 3'd6,
    BR    = 3'd7
  } op_t;

  localparam logic [8:0] HALT_WORD = 9'h1FF;
  localparam int         OP_MSB    = 8;
  localparam int         OP_LSB    = 6;

  // Opcodes whose EXEC cycle writes the register file directly.
  function automatic logic writes_reg(input op_t op);
    return (op == MOV) || (op == XOR) || (op == AND) || (op == SHIFT);
  endfunction

endpackage

`default_nettype wire

// File: rtl/feg_decode.sv
// ============================================================================
// Module   : feg_decode
// Purpose  : Combinational decode of the instruction register into datapath
//            fields and register/memory strobes for the current state.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module feg_decode
  import feg_pkg::*;
#(
  parameter int unsigned IW = 9
) (
  input  logic [IW-1:0] ir_i,
  input  state_t        state_i,
  output logic [2:0]    alu_cmd_o,
  output logic [1:0]    immed_o,
  output logic          direct_o,
  output logic [2:0]    ra_addr_o,
  output logic [2:0]    rb_addr_o,
  output logic          reg_we_o,
  output logic          mem_re_o,
  output logic          mem_we_o
);

  op_t op;
  assign op = op_t'(ir_i[OP_MSB:OP_LSB]);

  always_comb begin
    alu_cmd_o = '0;
    immed_o   = '0;
    direct_o  = 1'b0;
    ra_addr_o = '0;
    rb_addr_o = '0;
    reg_we_o  = 1'b0;
    mem_re_o  = 1'b0;
    mem_we_o  = 1'b0;

    if (state_i == EXEC || state_i == WB) begin
      alu_cmd_o = ir_i[OP_MSB:OP_LSB];
      immed_o   = ir_i[1:0];
      direct_o  = ir_i[2];
      ra_addr_o = ir_i[5:3];
      rb_addr_o = ir_i[2:0];
    end

    if (state_i == EXEC) begin
      case (op)
        LDR:     mem_re_o = 1'b1;
        STR:     mem_we_o = 1'b1;
        default: reg_we_o = writes_reg(op);
      endcase
    end else if (state_i == WB) begin
      // Load data is still being read while it is written back.
      mem_re_o = 1'b1;
      reg_we_o = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/feg_ctrl_fsm.sv
// ============================================================================
// Module   : feg_ctrl_fsm
// Purpose  : Multi-cycle sequencer for the FEG 8-bit datapath: PC, IR, CMP
//            flag, branch resolution and Start/Ack program handshake.
//            Optional FEG_PERF_CNT_EN adds instr_cnt/cycle_cnt outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module feg_ctrl_fsm
  import feg_pkg::*;
#(
  parameter int unsigned    PC_W      = 10,
  parameter int unsigned    IW        = 9,
  parameter int unsigned    BR_OFF_W  = 6,
  parameter logic [IW-1:0]  HALT_WORD = feg_pkg::HALT_WORD
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic [IW-1:0]   inst,
  input  logic            br_logic,
  output logic [PC_W-1:0] pc,
  output logic [2:0]      alu_cmd,
  output logic [1:0]      immed,
  output logic            direct,
  output logic [2:0]      ra_addr,
  output logic [2:0]      rb_addr,
  output logic            reg_we,
  output logic            mem_re,
  output logic            mem_we,
`ifdef FEG_PERF_CNT_EN
  output logic [15:0]     instr_cnt,
  output logic [15:0]     cycle_cnt,
`endif
  output logic            Ack
);

  state_t          state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic [IW-1:0]   ir_q;
  logic            flag_q;
  logic            ack_q;

  op_t             op;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] br_off;

  assign op     = op_t'(ir_q[OP_MSB:OP_LSB]);
  assign pc_inc = pc_q + PC_W'(1);
  assign br_off = PC_W'($signed(ir_q[BR_OFF_W-1:0]));

  // PC arithmetic is deliberately modulo 2^PC_W in both directions.
  always_comb begin
    pc_d = pc_inc;
    if (op == BR && flag_q) begin
      pc_d = pc_q + br_off;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      flag_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Start) begin
            state_q <= FETCH;
            pc_q    <= '0;
            flag_q  <= 1'b0;
          end
        end
        FETCH: begin
          ir_q <= inst;
          if (inst == HALT_WORD) begin
            state_q <= DONE;
            ack_q   <= 1'b1;
          end else begin
            state_q <= EXEC;
          end
        end
        EXEC: begin
          if (op == LDR) begin
            state_q <= WB;
          end else begin
            pc_q    <= pc_d;
            state_q <= FETCH;
            if (op == CMP) begin
              flag_q <= br_logic;
            end
          end
        end
        WB: begin
          pc_q    <= pc_inc;
          state_q <= FETCH;
        end
        DONE: begin
          if (!Start) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          ack_q   <= 1'b0;
        end
      endcase
    end
  end

  logic dec_reg_we;
  logic dec_mem_re;
  logic dec_mem_we;

  feg_decode #(
    .IW (IW)
  ) u_decode (
    .ir_i      (ir_q),
    .state_i   (state_q),
    .alu_cmd_o (alu_cmd),
    .immed_o   (immed),
    .direct_o  (direct),
    .ra_addr_o (ra_addr),
    .rb_addr_o (rb_addr),
    .reg_we_o  (dec_reg_we),
    .mem_re_o  (dec_mem_re),
    .mem_we_o  (dec_mem_we)
  );

  // A reset arriving mid-instruction must not let the write complete.
  assign reg_we = dec_reg_we & ~Reset;
  assign mem_re = dec_mem_re & ~Reset;
  assign mem_we = dec_mem_we & ~Reset;
  assign pc     = pc_q;
  assign Ack    = ack_q;

`ifdef FEG_PERF_CNT_EN
  logic [15:0] instr_cnt_q;
  logic [15:0] cycle_cnt_q;

  always_ff @(posedge Clk) begin
    if (Reset || (state_q == IDLE && Start)) begin
      instr_cnt_q <= '0;
      cycle_cnt_q <= '0;
    end else begin
      if ((state_q == FETCH || state_q == EXEC || state_q == WB) &&
          cycle_cnt_q != 16'hFFFF) begin
        cycle_cnt_q <= cycle_cnt_q + 16'd1;
      end
      if (state_q == FETCH && inst != HALT_WORD && instr_cnt_q != 16'hFFFF) begin
        instr_cnt_q <= instr_cnt_q + 16'd1;
      end
    end
  end

  assign instr_cnt = instr_cnt_q;
  assign cycle_cnt = cycle_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_feg_ctrl_fsm.sv
// ============================================================================
// Module   : tb_feg_ctrl_fsm
// Purpose  : Self-checking bench for feg_ctrl_fsm: instruction-level model
//            expanded into per-cycle expectations, plus directed checks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_feg_ctrl_fsm;

  localparam logic [8:0] HALT = 9'h1FF;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic        br_logic = 1'b0;
  logic [8:0]  inst;
  logic [9:0]  pc;
  logic [2:0]  alu_cmd;
  logic [1:0]  immed;
  logic        direct;
  logic [2:0]  ra_addr;
  logic [2:0]  rb_addr;
  logic        reg_we;
  logic        mem_re;
  logic        mem_we;
  logic        Ack;
`ifdef FEG_PERF_CNT_EN
  logic [15:0] instr_cnt;
  logic [15:0] cycle_cnt;
`endif

  logic [8:0] rom [1024];
  assign inst = rom[pc];

  feg_ctrl_fsm dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .inst     (inst),
    .br_logic (br_logic),
    .pc       (pc),
    .alu_cmd  (alu_cmd),
    .immed    (immed),
    .direct   (direct),
    .ra_addr  (ra_addr),
    .rb_addr  (rb_addr),
    .reg_we   (reg_we),
    .mem_re   (mem_re),
    .mem_we   (mem_we),
`ifdef FEG_PERF_CNT_EN
    .instr_cnt(instr_cnt),
    .cycle_cnt(cycle_cnt),
`endif
    .Ack      (Ack)
  );

  always #5 Clk = ~Clk;

  int n_chk  = 0;
  int n_fail = 0;
  int we_cnt = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // ---------------- instruction-level reference model ----------------
  typedef struct packed {
    logic [2:0] alu;
    logic [1:0] imm;
    logic       dir;
    logic [2:0] ra;
    logic [2:0] rb;
    logic       rwe;
    logic       mre;
    logic       mwe;
  } rec_t;

  int         m_mode = 0;   // 0 idle, 1 running, 2 done
  int         m_pc   = 0;
  bit         m_flag = 1'b0;
  logic [8:0] m_ir   = '0;
  rec_t       m_q[$];

  task automatic model_retire();
    int op;
    int off;
    op  = int'(m_ir[8:6]);
    off = int'(m_ir[5:0]);
    if (off >= 32) off -= 64;
    if (op == 6) m_flag = br_logic;
    if (op == 7 && m_flag) m_pc = (m_pc + off + 1024) % 1024;
    else                   m_pc = (m_pc + 1) % 1024;
  endtask

  task automatic model_fetch();
    rec_t r;
    int   op;
    m_ir = rom[m_pc];
    if (m_ir == HALT) begin
      m_mode = 2;
    end else begin
      op    = int'(m_ir[8:6]);
      r.alu = m_ir[8:6];
      r.imm = m_ir[1:0];
      r.dir = m_ir[2];
      r.ra  = m_ir[5:3];
      r.rb  = m_ir[2:0];
      r.rwe = (op >= 2 && op <= 5);
      r.mre = (op == 0);
      r.mwe = (op == 1);
      m_q.push_back(r);
      if (op == 0) begin
        r.rwe = 1'b1;
        r.mre = 1'b1;
        m_q.push_back(r);
      end
    end
  endtask

  always @(posedge Clk) begin
    if (Reset) begin
      m_mode = 0;
      m_pc   = 0;
      m_flag = 1'b0;
      m_q.delete();
    end else if (m_mode == 0) begin
      if (Start) begin
        m_mode = 1;
        m_pc   = 0;
        m_flag = 1'b0;
      end
    end else if (m_mode == 2) begin
      if (!Start) m_mode = 0;
    end else if (m_q.size() == 0) begin
      model_fetch();
    end else begin
      void'(m_q.pop_front());
      if (m_q.size() == 0) model_retire();
    end
  end

  rec_t        cmp_rec;
  logic [25:0] cmp_act;
  logic [25:0] cmp_exp;

  always @(negedge Clk) begin
    if (chk_en) begin
      cmp_rec = (m_q.size() > 0) ? m_q[0] : '0;
      if (Reset) begin
        cmp_rec.rwe = 1'b0;
        cmp_rec.mre = 1'b0;
        cmp_rec.mwe = 1'b0;
      end
      cmp_act = {pc, Ack, alu_cmd, immed, direct, ra_addr, rb_addr, reg_we, mem_re, mem_we};
      cmp_exp = {10'(m_pc), (m_mode == 2), cmp_rec};
      n_chk++;
      if (cmp_act !== cmp_exp) begin
        n_fail++;
        $display("FAIL cycle_outputs t=%0t: got pc=%0d ack=%b dec=%h, expected pc=%0d ack=%b dec=%h",
                 $time, cmp_act[25:16], cmp_act[15], cmp_act[14:0],
                 cmp_exp[25:16], cmp_exp[15], cmp_exp[14:0]);
      end
    end
  end

  always @(negedge Clk) begin
    if (reg_we === 1'b1) we_cnt++;
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge Clk);
    #2;
  endtask

  task automatic wait_ack(input int budget, input string nm);
    int k;
    k = 0;
    while (Ack !== 1'b1 && k < budget) begin
      step();
      k++;
    end
    chk(nm, {31'd0, Ack}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = HALT;
    Reset = 1'b1;
    step();
    chk_en = 1'b1;
    step();
    chk("rst_pc", {22'd0, pc}, 32'd0);
    chk("rst_ack", {31'd0, Ack}, 32'd0);
    chk("rst_strobes", {29'd0, reg_we, mem_re, mem_we}, 32'd0);
    Reset = 1'b0;
    step();

    // MOV then HALT
    rom[0] = 9'b010_000_011;
    rom[1] = HALT;
    we_cnt = 0;
    Start = 1'b1; step();
    Start = 1'b0; step();
    chk("mov_reg_we", {31'd0, reg_we}, 32'd1);
    chk("mov_immed", {30'd0, immed}, 32'd3);
    step(); step();
    chk("mov_ack", {31'd0, Ack}, 32'd1);
    chk("mov_pc", {22'd0, pc}, 32'd1);
    chk("mov_we_once", we_cnt, 32'd1);
    step();
    chk("mov_ack_drop", {31'd0, Ack}, 32'd0);

    // LDR: mem_re for EXEC and WB, reg_we only in WB
    rom[0] = 9'b000_001_010;
    Start = 1'b1; step();
    Start = 1'b0; step();
    chk("ldr_exec_re", {31'd0, mem_re}, 32'd1);
    chk("ldr_exec_we", {31'd0, reg_we}, 32'd0);
    step();
    chk("ldr_wb_re", {31'd0, mem_re}, 32'd1);
    chk("ldr_wb_we", {31'd0, reg_we}, 32'd1);
    chk("ldr_wb_rb", {29'd0, rb_addr}, 32'd2);
    step();
    chk("ldr_pc", {22'd0, pc}, 32'd1);
    wait_ack(4, "ldr_ack");
    step();

    // Taken branches: CMP(1), BR +3 -> 4, CMP(1), BR -2 at pc 5 -> 3 (HALT)
    rom[0] = 9'h180; rom[1] = 9'h1C3; rom[2] = HALT; rom[3] = HALT;
    rom[4] = 9'h180; rom[5] = 9'h1FE;
    br_logic = 1'b1;
    Start = 1'b1; step();
    Start = 1'b0;
    wait_ack(20, "br_taken_ack");
    chk("br_taken_pc", {22'd0, pc}, 32'd3);
    step();

    // Not taken: MOV x4, CMP(0), BR -2 at pc 5 -> 6 (HALT)
    for (int i = 0; i < 4; i++) rom[i] = 9'h080;
    rom[6] = HALT;
    br_logic = 1'b0;
    Start = 1'b1; step();
    Start = 1'b0;
    wait_ack(30, "br_not_taken_ack");
    chk("br_not_taken_pc", {22'd0, pc}, 32'd6);
    step();

    // Wrap: BR -2 from pc 1 -> 1023, XOR at 1023 -> pc 0
    rom[0] = 9'h180; rom[1] = 9'h1FE; rom[2] = HALT; rom[1023] = 9'b011_101_001;
    br_logic = 1'b1;
    Start = 1'b1; step();
    Start = 1'b0; step(); step(); step(); step();
    chk("wrap_pc_max", {22'd0, pc}, 32'd1023);
    step();
    chk("wrap_xor_we", {31'd0, reg_we}, 32'd1);
    chk("wrap_xor_cmd", {29'd0, alu_cmd}, 32'd3);
    chk("wrap_xor_ra", {29'd0, ra_addr}, 32'd5);
    step();
    chk("wrap_pc_zero", {22'd0, pc}, 32'd0);
    br_logic = 1'b0;
    wait_ack(20, "wrap_ack");
    chk("wrap_final_pc", {22'd0, pc}, 32'd2);
    step();

    // Reset during EXEC of STR
    rom[0] = 9'h080; rom[1] = 9'h040; rom[2] = HALT;
    Start = 1'b1; step();
    Start = 1'b0; step(); step(); step();
    chk("str_we_before", {31'd0, mem_we}, 32'd1);
    Reset = 1'b1;
    #1;
    chk("str_we_aborted", {31'd0, mem_we}, 32'd0);
    step();
    chk("str_rst_pc", {22'd0, pc}, 32'd0);
    chk("str_rst_ack", {31'd0, Ack}, 32'd0);
    Reset = 1'b0;
    step(); step();
    chk("str_idle_pc", {22'd0, pc}, 32'd0);

    // DONE hold with Start high, drop, restart
    rom[0] = 9'h080; rom[1] = HALT;
    Start = 1'b1;
    wait_ack(10, "hold_ack");
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_ack_stays", {31'd0, Ack}, 32'd1);
      chk("hold_pc_stays", {22'd0, pc}, 32'd1);
    end
    Start = 1'b0; step();
    chk("hold_ack_drop", {31'd0, Ack}, 32'd0);
    Start = 1'b1; step();
    chk("restart_pc", {22'd0, pc}, 32'd0);
    wait_ack(10, "restart_ack");
    chk("restart_final_pc", {22'd0, pc}, 32'd1);
    Start = 1'b0;
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/feg_ctrl_fsm.md
Name: feg_ctrl_fsm

Overview:
Multi-cycle sequencer for the FEG 8-bit datapath. Holds the PC and instruction register, decodes each 9-bit instruction into ALU command/immediate/direction fields and register/memory strobes, latches the CMP flag, resolves branches and runs the Start/Ack program handshake. Sits between instruction ROM and the register file, data memory and ALU.

Parameters:
PC_W, 10, program counter width in bits
IW, 9, instruction width in bits
BR_OFF_W, 6, signed branch offset width (inst[5:0])
HALT_WORD, 9'h1FF, encoding that terminates the program

Ports:
Clk  in  1  system clock, all state on rising edge
Reset  in  1  synchronous, active-high
Start  in  1  program request, level sampled in IDLE/DONE
inst  in  IW  instruction ROM data, valid combinationally for pc
br_logic  in  1  ALU compare-equal flag
pc  out  PC_W  instruction ROM address
alu_cmd  out  3  ALU opcode = ir[8:6]
immed  out  2  ir[1:0]
direct  out  1  ir[2] (1 = right shift)
ra_addr  out  3  ir[5:3]
rb_addr  out  3  ir[2:0]
reg_we  out  1  register file write strobe
mem_re  out  1  data memory read enable
mem_we  out  1  data memory write strobe
Ack  out  1  program complete

Behaviour:
- Reset: state=IDLE, pc=0, ir=0, flag=0, Ack=0; all strobes 0. Reset mid-instruction aborts it with no write.
- States: IDLE, FETCH, EXEC, WB, DONE.
- IDLE: Start=1 -> FETCH, pc=0, flag=0.
- FETCH (1 cycle): ir<=inst. If inst==HALT_WORD -> DONE, otherwise EXEC.
- EXEC, decoded from ir; alu_cmd/immed/direct/ra/rb driven from ir in EXEC and WB, held at 0 elsewhere:
  - 000 LDR: mem_re=1 -> WB.
  - 001 STR: mem_we=1 for 1 cycle; pc+=1 -> FETCH.
  - 010 MOV, 011 XOR, 100 AND, 101 SHIFT: reg_we=1 for 1 cycle; pc+=1 -> FETCH.
  - 110 CMP: flag<=br_logic, no write; pc+=1 -> FETCH.
  - 111 BR: if flag, pc<=pc+sext(ir[5:0]), otherwise pc+=1 -> FETCH. Flag persists until the next CMP.
- WB (LDR only): mem_re=1, reg_we=1 for 1 cycle; pc+=1 -> FETCH.
- Cycles per instruction: 2, LDR 3, HALT 1 plus DONE.
- PC arithmetic is modulo 2^PC_W. Wrap past max and negative offsets below 0 wrap silently.
- DONE: Ack=1 while in DONE. Start=0 -> IDLE, Ack drops the next cycle. Start held high keeps DONE, so a program never auto-restarts.
- Start is ignored outside IDLE/DONE.
- At most one of reg_we/mem_we is high in any cycle.

Optional Feature:
FEG_PERF_CNT_EN:
- Defined: adds outputs instr_cnt[15:0] and cycle_cnt[15:0].
  - Both clear on Reset and on IDLE->FETCH.
  - cycle_cnt increments every non-IDLE/DONE cycle.
  - instr_cnt increments on each FETCH->EXEC.
  - Both saturate at 16'hFFFF and hold their value in DONE.
- Undefined: ports and logic absent.

Decomposition:
- Package feg_pkg: enum state_t (IDLE, FETCH, EXEC, WB, DONE), enum op_t (LDR=0, STR, MOV, XOR, AND, SHIFT, CMP, BR), localparam HALT_WORD, field slice constants OP_MSB/OP_LSB.
- One sub-module feg_decode: combinational, ir and state -> alu_cmd/immed/direct/ra/rb/reg_we/mem_re/mem_we. The FSM, PC and flag stay in feg_ctrl_fsm.

Test Plan:
- Reset then Start=1, ROM[0]=MOV (9'b010_000_011), ROM[1]=9'h1FF -> reg_we high exactly once in cycle 2 with immed=3; Ack=1 by cycle 4; pc=1.
- LDR at ROM[0] -> mem_re high 2 cycles, reg_we only in the WB cycle; pc reaches 1 three cycles after FETCH.
- CMP with br_logic=1, then BR offset 6'h3E (-2) at pc=5 -> pc=3. Repeat with br_logic=0 -> pc=6.
- pc=1023 executing XOR -> pc wraps to 0.
- Reset asserted during EXEC of STR -> mem_we=0 that cycle, state IDLE, pc=0.
- After DONE hold Start=1 for 5 cycles -> Ack stays 1 and pc unchanged. Drop Start -> Ack=0 next cycle. Re-raise Start -> restart from pc=0.
